// File: rtl/cordic_gain_comp.sv
// cordic_gain_comp: output stage of the S1.12 vectoring CORDIC. It scales the final X by K to remove the CORDIC gain.
// The optional residual-Y convergence flag is built only when CORDIC_RESID_CHK_EN is defined.
module cordic_gain_comp #(
    parameter int          WIDTH     = 14,
    parameter int          FRAC      = 12,
    parameter int unsigned K_CONST   = 2487,
    parameter int unsigned RESID_TOL = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic signed [WIDTH-1:0] y_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] mag_out,
    output logic                    resid_err,
    output logic [15:0]             out_count
);

    localparam int PW = 2 * WIDTH;
    localparam logic signed [PW-1:0] K_EXT    = PW'(K_CONST);
    localparam logic signed [PW-1:0] HALF_LSB = PW'(2 ** (FRAC - 1));

    logic                 s1_valid;
    logic                 s2_valid;
    logic                 s2_load;
    logic                 accept;
    logic signed [PW-1:0] x_ext;
    logic signed [PW-1:0] prod_next;
    logic signed [PW-1:0] s1_prod;
    logic signed [PW-1:0] rounded;
    logic [WIDTH-1:0]     mag_next;
    logic                 unused_round;

    // S2 refills whenever it is empty or its sample leaves this cycle; S1 can then take a new sample.
    assign s2_load   = s1_valid && (!s2_valid || out_ready);
    assign in_ready  = !s1_valid || s2_load;
    assign accept    = in_valid && in_ready;
    assign out_valid = s2_valid;

    assign x_ext     = {{(PW - WIDTH){x_in[WIDTH-1]}}, x_in};
    assign prod_next = x_ext * K_EXT;

    // Round half up. |x| < 2.0 keeps the result well inside WIDTH bits, so no saturation is needed.
    assign rounded      = s1_prod + HALF_LSB;
    assign mag_next     = rounded[FRAC +: WIDTH];
    assign unused_round = ^{rounded[PW-1:FRAC+WIDTH], rounded[FRAC-1:0]};

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    // NOTE: the product register is not reset; s1_valid alone qualifies it.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_prod <= prod_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            mag_out  <= '0;
        end else if (s2_load) begin
            s2_valid <= 1'b1;
            mag_out  <= mag_next;
        end else if (out_ready) begin
            s2_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_count <= '0;
        end else if (s2_valid && out_ready) begin
            out_count <= out_count + 16'd1;
        end
    end

`ifdef CORDIC_RESID_CHK_EN
    logic [WIDTH:0] y_wide;
    logic [WIDTH:0] y_abs;
    logic           resid_next;
    logic           s1_resid;

    // One extra bit lets the most negative input fold to a positive magnitude.
    assign y_wide     = {y_in[WIDTH-1], y_in};
    assign y_abs      = y_in[WIDTH-1] ? (~y_wide + (WIDTH + 1)'(1)) : y_wide;
    assign resid_next = y_abs > (WIDTH + 1)'(RESID_TOL);

    always_ff @(posedge clk) begin
        if (accept) begin
            s1_resid <= resid_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resid_err <= 1'b0;
        end else if (s2_load) begin
            resid_err <= s1_resid;
        end
    end
`else
    logic unused_resid;

    assign unused_resid = ^{y_in, 1'(RESID_TOL)};
    assign resid_err    = 1'b0;
`endif

endmodule

// File: tb/tb_cordic_gain_comp.sv
// Self-checking bench for cordic_gain_comp: a queue-based arithmetic model checked every cycle, plus directed literals.
module tb_cordic_gain_comp;

    typedef struct {
        logic signed [13:0] mag;
        logic               resid;
    } exp_t;

`ifdef CORDIC_RESID_CHK_EN
    localparam logic RES_ON = 1'b1;
`else
    localparam logic RES_ON = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic signed [13:0] x_in;
    logic signed [13:0] y_in;
    logic               out_valid;
    logic               out_ready;
    logic signed [13:0] mag_out;
    logic               resid_err;
    logic [15:0]        out_count;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t exp_q[$];
    int   exp_cnt = 0;

    cordic_gain_comp dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .y_in      (y_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mag_out   (mag_out),
        .resid_err (resid_err),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Magnitude is x * 0.60718 (K = 2487/4096) rounded to nearest, halves rounded up.
    function automatic exp_t model(input logic signed [13:0] x, input logic signed [13:0] y);
        exp_t e;
        real  scaled;
        int   yi;
        scaled  = real'(int'(x)) * 2487.0 / 4096.0;
        e.mag   = 14'(int'($floor(scaled + 0.5)));
        yi      = int'(y);
        e.resid = RES_ON && (((yi < 0) ? -yi : yi) > 16);
        return e;
    endfunction

    // Outputs and handshakes are observed on the falling edge, half a cycle away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            exp_cnt = 0;
        end else begin
            check("out_count", out_count, 64'(exp_cnt));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out_valid", out_valid, 0);
                end else begin
                    check("mag_out", mag_out, exp_q[0].mag);
                    check("resid_err", resid_err, exp_q[0].resid);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        exp_cnt = (exp_cnt + 1) % 65536;
                    end
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(x_in, y_in));
        end
    end

    // Single sample into an idle pipeline: checks acceptance, latency and the hand-computed result.
    task automatic send_one(input logic signed [13:0] x, input logic signed [13:0] y,
                            input logic signed [13:0] exp_mag, input logic exp_res, input string tag);
        int lat;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        x_in      = x;
        y_in      = y;
        check({tag, "_in_ready"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, lat, 2);
        check({tag, "_mag"}, mag_out, exp_mag);
        check({tag, "_resid"}, resid_err, exp_res);
        @(posedge clk); #1;
    endtask

    // Streams n samples, holding out_ready low for cycles [stall_start, stall_start+stall_len).
    task automatic stream(input int n, input int seed, input int stall_start, input int stall_len,
                          output int acc_stall, output int drops);
        int  sent = 0;
        int  cyc  = 0;
        bit  acc;
        bit  stalled;
        acc_stall = 0;
        drops     = 0;
        while (sent < n && cyc < 2 * n + stall_len + 50) begin
            stalled   = (cyc >= stall_start) && (cyc < stall_start + stall_len);
            out_ready = !stalled;
            in_valid  = 1'b1;
            x_in      = 14'(((sent * 1237 + seed) % 16383) - 8191);
            y_in      = 14'(((sent * 37 + seed) % 64) - 32);
            @(negedge clk);
            acc = in_ready;
            if (!acc) drops++;
            if (stalled && acc) acc_stall++;
            @(posedge clk); #1;
            if (acc) sent++;
            cyc++;
        end
        check("stream_sent", sent, n);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8 && out_valid; i++) begin
            @(posedge clk); #1;
        end
        check("stream_drained", out_valid, 0);
    endtask

    initial begin
        int acc_stall;
        int drops;
        int remaining;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        x_in      = '0;
        y_in      = '0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_count", out_count, 0);
        check("rst_mag_out", mag_out, 0);
        check("rst_resid_err", resid_err, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        send_one(14'sd4096, 14'sd0, 14'sd2487, 1'b0, "gain_one");
        send_one(14'sd6745, 14'sd16, 14'sd4095, 1'b0, "gain_max");
        send_one(-14'sd4096, 14'sd17, -14'sd2487, RES_ON, "gain_neg");
        send_one(14'sd0, -14'sd17, 14'sd0, RES_ON, "gain_zero");
        send_one(14'sd4096, -14'sd8192, 14'sd2487, RES_ON, "resid_min");
        check("count_after_directed", out_count, 5);

        // Two samples in flight behind a stalled output, then an asynchronous reset.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        x_in      = 14'sd1000;
        @(posedge clk); #1;
        x_in      = 14'sd2000;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        check("pre_reset_out_valid", out_valid, 1);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_count", out_count, 0);
        @(posedge clk); #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("post_reset_idle", out_valid, 0);
        end

        stream(100, 11, 1000, 0, acc_stall, drops);
        check("stream_in_ready_drops", drops, 0);
        check("stream_out_count", out_count, 100);

        stream(7, 503, 0, 5, acc_stall, drops);
        check("bp_empty_accepts", acc_stall, 2);
        check("bp_empty_ready_low", drops, 3);

        stream(20, 977, 8, 5, acc_stall, drops);
        check("bp_full_accepts", acc_stall, 0);
        check("bp_full_ready_low", drops, 5);

        remaining = 65535 - exp_cnt;
        stream(remaining, 4242, 1 << 30, 0, acc_stall, drops);
        check("wrap_preload", out_count, 16'hFFFF);
        send_one(14'sd4096, 14'sd0, 14'sd2487, 1'b0, "wrap_last");
        check("wrap_out_count", out_count, 0);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
